// File: rtl/mul_long_unit_pkg.sv
// Shared definitions for the iterative long multiplier: FSM encoding,
// counter sizing and the opcode decode table reused by the control unit.
package mul_long_unit_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_BPC   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } mul_state_e;

  typedef enum logic [2:0] {
    OP_MUL   = 3'd0,
    OP_MLA   = 3'd1,
    OP_UMULL = 3'd2,
    OP_SMULL = 3'd3,
    OP_UMLAL = 3'd4,
    OP_SMLAL = 3'd5
  } mul_op_e;

  typedef struct packed {
    logic is_signed;
    logic accumulate;
  } mul_ctrl_t;

  localparam mul_ctrl_t CTRL_MUL   = '{is_signed: 1'b0, accumulate: 1'b0};
  localparam mul_ctrl_t CTRL_MLA   = '{is_signed: 1'b0, accumulate: 1'b1};
  localparam mul_ctrl_t CTRL_UMULL = '{is_signed: 1'b0, accumulate: 1'b0};
  localparam mul_ctrl_t CTRL_SMULL = '{is_signed: 1'b1, accumulate: 1'b0};
  localparam mul_ctrl_t CTRL_UMLAL = '{is_signed: 1'b0, accumulate: 1'b1};
  localparam mul_ctrl_t CTRL_SMLAL = '{is_signed: 1'b1, accumulate: 1'b1};

  // Iteration counter must hold WIDTH/BPC itself, hence the +1.
  function automatic int cnt_width(input int width, input int bpc);
    return $clog2(width / bpc + 1);
  endfunction

  function automatic mul_ctrl_t mul_decode(input mul_op_e op);
    mul_ctrl_t c;
    case (op)
      OP_MUL:   c = CTRL_MUL;
      OP_MLA:   c = CTRL_MLA;
      OP_UMULL: c = CTRL_UMULL;
      OP_SMULL: c = CTRL_SMULL;
      OP_UMLAL: c = CTRL_UMLAL;
      OP_SMLAL: c = CTRL_SMLAL;
      default:  c = CTRL_MUL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_long_unit_step.sv
// One RUN iteration: add mcand * mbits into the double-width partial product.
// mcand arrives already shifted to the current bit position.
module mul_long_unit_step
  import mul_long_unit_pkg::*;
#(
  parameter int WIDTH          = MUL_WIDTH,
  parameter int BITS_PER_CYCLE = MUL_BPC
) (
  input  logic [2*WIDTH-1:0]        partial_in,
  input  logic [2*WIDTH-1:0]        mcand,
  input  logic [BITS_PER_CYCLE-1:0] mbits,
  output logic [2*WIDTH-1:0]        partial_out
);

  // Shift-and-add over the retired multiplier bits.
  always_comb begin
    partial_out = partial_in;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      if (mbits[i]) begin
        partial_out = partial_out + (mcand << i);
      end
    end
  end

endmodule

// File: rtl/mul_long_unit.sv
// Iterative 32x32->64 multiply / multiply-accumulate for the execute stage.
// Magnitudes are multiplied unsigned; the sign is applied once in FIX.
//
//  state | meaning
//  IDLE  | waiting for start; operands latched on accept
//  RUN   | retire BITS_PER_CYCLE multiplier bits per cycle, count down
//  FIX   | apply sign, add accumulator, register result and flags
//  DONE  | one-cycle done pulse, then back to IDLE
module mul_long_unit
  import mul_long_unit_pkg::*;
#(
  parameter int WIDTH          = MUL_WIDTH,
  parameter int BITS_PER_CYCLE = MUL_BPC
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             flush,
  input  logic             is_signed,
  input  logic             accumulate,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] acc_hi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int                PW       = 2 * WIDTH;
  localparam int                CNT_W    = cnt_width(WIDTH, BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH / BITS_PER_CYCLE);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  mul_state_e       state_q,     state_d;
  logic [CNT_W-1:0] count_q,     count_d;
  logic [PW-1:0]    mcand_q,     mcand_d;
  logic [WIDTH-1:0] mplier_q,    mplier_d;
  logic [PW-1:0]    partial_q,   partial_d;
  logic [PW-1:0]    acc_q,       acc_d;
  logic             neg_q,       neg_d;
  logic             accum_q,     accum_d;
  logic             busy_q,      busy_d;
  logic             done_q,      done_d;
  logic [WIDTH-1:0] result_lo_q, result_lo_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             flag_n_q,    flag_n_d;
  logic             flag_z_q,    flag_z_d;

  logic [WIDTH-1:0] abs_a, abs_b;
  logic [PW-1:0]    step_sum;
  logic [PW-1:0]    signed_prod;
  logic [PW-1:0]    fix_value;

  mul_long_unit_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .partial_in  (partial_q),
    .mcand       (mcand_q),
    .mbits       (mplier_q[BITS_PER_CYCLE-1:0]),
    .partial_out (step_sum)
  );

  // Operand magnitudes and the FIX-stage sign/accumulate result.
  // abs(MIN) wraps back to MIN, which is the right unsigned magnitude.
  always_comb begin
    abs_a       = (is_signed && SrcA[WIDTH-1]) ? -SrcA : SrcA;
    abs_b       = (is_signed && SrcB[WIDTH-1]) ? -SrcB : SrcB;
    signed_prod = neg_q ? -partial_q : partial_q;
    fix_value   = signed_prod + (accum_q ? acc_q : '0);
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    partial_d   = partial_q;
    acc_d       = acc_q;
    neg_d       = neg_q;
    accum_d     = accum_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    result_lo_d = result_lo_q;
    result_hi_d = result_hi_q;
    flag_n_d    = flag_n_q;
    flag_z_d    = flag_z_q;

    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          mcand_d   = {{WIDTH{1'b0}}, abs_a};
          mplier_d  = abs_b;
          acc_d     = {acc_hi, acc_lo};
          accum_d   = accumulate;
          neg_d     = is_signed & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          partial_d = '0;
          count_d   = CNT_LOAD;
          busy_d    = 1'b1;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          partial_d = step_sum;
          mcand_d   = mcand_q << BITS_PER_CYCLE;
          mplier_d  = mplier_q >> BITS_PER_CYCLE;
          count_d   = count_q - CNT_ONE;
          busy_d    = 1'b1;
          if (count_q == CNT_ONE) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          result_lo_d = fix_value[WIDTH-1:0];
          result_hi_d = fix_value[PW-1:WIDTH];
          flag_n_d    = fix_value[PW-1];
          flag_z_d    = (fix_value == '0);
          done_d      = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      partial_q   <= '0;
      acc_q       <= '0;
      neg_q       <= 1'b0;
      accum_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_lo_q <= '0;
      result_hi_q <= '0;
      flag_n_q    <= 1'b0;
      flag_z_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      partial_q   <= partial_d;
      acc_q       <= acc_d;
      neg_q       <= neg_d;
      accum_q     <= accum_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_lo_q <= result_lo_d;
      result_hi_q <= result_hi_d;
      flag_n_q    <= flag_n_d;
      flag_z_q    <= flag_z_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = result_lo_q;
  assign result_hi = result_hi_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_mul_long_unit.sv
// Directed-vector bench for mul_long_unit with hand-computed expectations.
module tb_mul_long_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic        is_signed;
  logic        accumulate;
  logic [31:0] SrcA, SrcB, acc_lo, acc_hi;
  logic        busy, done, flag_n, flag_z;
  logic [31:0] result_lo, result_hi;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mul_long_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .flush      (flush),
    .is_signed  (is_signed),
    .accumulate (accumulate),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .acc_lo     (acc_lo),
    .acc_hi     (acc_hi),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .flag_n     (flag_n),
    .flag_z     (flag_z)
  );

  task automatic drive_ops(input logic [31:0] a, b, ahi, alo, input logic sgn, acc);
    SrcA = a; SrcB = b; acc_hi = ahi; acc_lo = alo; is_signed = sgn; accumulate = acc;
  endtask

  // Launch from IDLE; lat = edges after the accept edge until done (-1 on timeout).
  // Returns one edge after done so the unit is back in IDLE.
  task automatic run_op(input logic [31:0] a, b, ahi, alo, input logic sgn, acc,
                        output int lat, output int busy_cnt);
    @(negedge clk);
    drive_ops(a, b, ahi, alo, sgn, acc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
      if (busy) busy_cnt++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; flush = 1'b0;
    drive_ops(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, done, flag_n, flag_z, result_hi, result_lo} !== 68'h0) begin
      fails++;
      $display("FAIL reset_outputs got busy=%0b done=%0b n=%0b z=%0b hi=%h lo=%h want all 0",
               busy, done, flag_n, flag_z, result_hi, result_lo);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_unsigned();
    int lat, bc;
    run_op(32'd7, 32'd6, 32'h0, 32'h0, 1'b0, 1'b0, lat, bc);
    tests++;
    if (lat !== 17) begin fails++; $display("FAIL u_latency got %0d want 17", lat); end
    tests++;
    if (bc !== 17) begin fails++; $display("FAIL u_busy_cycles got %0d want 17", bc); end
    tests++;
    if ({result_hi, result_lo} !== 64'd42) begin
      fails++; $display("FAIL u_7x6 got %h_%h want 0_2a", result_hi, result_lo);
    end
    tests++;
    if ({flag_n, flag_z} !== 2'b00) begin
      fails++; $display("FAIL u_flags got n=%0b z=%0b want 0 0", flag_n, flag_z);
    end
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_one_cycle got %0b want 0", done); end
  endtask

  task automatic test_signed();
    int lat, bc;
    run_op(32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0, 1'b1, 1'b0, lat, bc);
    tests++;
    if ({result_hi, result_lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      fails++; $display("FAIL s_m3x5 got %h_%h want ffffffff_fffffff1", result_hi, result_lo);
    end
    tests++;
    if ({flag_n, flag_z} !== 2'b10) begin
      fails++; $display("FAIL s_m3x5_flags got n=%0b z=%0b want 1 0", flag_n, flag_z);
    end
    run_op(32'hFFFF_FFFD, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0, lat, bc);
    tests++;
    if ({result_hi, result_lo} !== 64'h0000_0004_FFFF_FFF1) begin
      fails++; $display("FAIL u_fffffffdx5 got %h_%h want 00000004_fffffff1", result_hi, result_lo);
    end
    tests++;
    if (flag_n !== 1'b0) begin fails++; $display("FAIL u_fffffffdx5_n got %0b want 0", flag_n); end
  endtask

  task automatic test_extremes();
    int lat, bc;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0, 1'b0, lat, bc);
    tests++;
    if ({result_hi, result_lo} !== 64'hFFFF_FFFE_0000_0001) begin
      fails++; $display("FAIL u_max got %h_%h want fffffffe_00000001", result_hi, result_lo);
    end
    run_op(32'h8000_0000, 32'h8000_0000, 32'h0, 32'h0, 1'b1, 1'b0, lat, bc);
    tests++;
    if ({result_hi, result_lo} !== 64'h4000_0000_0000_0000) begin
      fails++; $display("FAIL s_min_min got %h_%h want 40000000_00000000", result_hi, result_lo);
    end
    tests++;
    if (flag_n !== 1'b0) begin fails++; $display("FAIL s_min_min_n got %0b want 0", flag_n); end
    run_op(32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, lat, bc);
    tests++;
    if (lat !== 17) begin fails++; $display("FAIL zero_latency got %0d want 17", lat); end
    tests++;
    if ({result_hi, result_lo, flag_z} !== {64'h0, 1'b1}) begin
      fails++; $display("FAIL zero_result got %h_%h z=%0b want 0 z=1", result_hi, result_lo, flag_z);
    end
  endtask

  task automatic test_accumulate();
    int lat, bc;
    run_op(32'd3, 32'd4, 32'h0, 32'hFFFF_FFF8, 1'b0, 1'b1, lat, bc);
    tests++;
    if ({result_hi, result_lo} !== 64'h0000_0001_0000_0004) begin
      fails++; $display("FAIL acc_carry got %h_%h want 00000001_00000004", result_hi, result_lo);
    end
    run_op(32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, lat, bc);
    tests++;
    if ({result_hi, result_lo, flag_z, flag_n} !== {64'h0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL acc_wrap got %h_%h z=%0b n=%0b want 0 z=1 n=0",
                        result_hi, result_lo, flag_z, flag_n);
    end
    run_op(32'hFFFF_FFFE, 32'd3, 32'h0, 32'd10, 1'b1, 1'b1, lat, bc);
    tests++;
    if ({result_hi, result_lo} !== 64'd4) begin
      fails++; $display("FAIL acc_signed got %h_%h want 0_4", result_hi, result_lo);
    end
  endtask

  task automatic test_start_ignored();
    int done_cnt, first_k, second_k;
    logic [63:0] r1, r2;
    done_cnt = 0; first_k = -1; second_k = -1; r1 = '0; r2 = '0;
    @(negedge clk);
    drive_ops(32'd7, 32'd6, 32'h0, 32'h0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin first_k = k; r1 = {result_hi, result_lo}; end
        else begin second_k = k; r2 = {result_hi, result_lo}; end
      end
      if (k == 19) begin
        tests++;
        if (busy !== 1'b1) begin fails++; $display("FAIL start_after_done busy got %0b want 1", busy); end
      end
      start = 1'b0;
      if (k == 4 || k == 18) begin
        drive_ops(32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 1'b0);
        start = 1'b1;
      end
    end
    tests++;
    if (done_cnt !== 2) begin fails++; $display("FAIL ignored_done_count got %0d want 2", done_cnt); end
    tests++;
    if (first_k !== 17 || r1 !== 64'd42) begin
      fails++; $display("FAIL ignored_first got k=%0d r=%h want k=17 r=2a", first_k, r1);
    end
    tests++;
    if (second_k !== 36 || r2 !== 64'd81) begin
      fails++; $display("FAIL third_start got k=%0d r=%h want k=36 r=51", second_k, r2);
    end
  endtask

  task automatic test_abort();
    int lat, bc;
    logic saw_done;
    run_op(32'd9, 32'd9, 32'h0, 32'h0, 1'b0, 1'b0, lat, bc);
    @(negedge clk);
    drive_ops(32'd7, 32'd6, 32'h0, 32'h0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL flush_busy got %0b want 0", busy); end
    saw_done = 1'b0;
    repeat (25) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    tests++;
    if (saw_done !== 1'b0) begin fails++; $display("FAIL flush_no_done got %0b want 0", saw_done); end
    tests++;
    if ({result_hi, result_lo} !== 64'd81) begin
      fails++; $display("FAIL flush_result_held got %h_%h want 0_51", result_hi, result_lo);
    end

    @(negedge clk);
    drive_ops(32'd5, 32'd5, 32'h0, 32'h0, 1'b0, 1'b0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1; reset = 1'b0;
    @(posedge clk); #1;
    tests++;
    if ({busy, done, flag_n, flag_z, result_hi, result_lo} !== 68'h0) begin
      fails++;
      $display("FAIL midop_reset got busy=%0b done=%0b n=%0b z=%0b hi=%h lo=%h want all 0",
               busy, done, flag_n, flag_z, result_hi, result_lo);
    end
    reset = 1'b1;
    run_op(32'd7, 32'd6, 32'h0, 32'h0, 1'b0, 1'b0, lat, bc);
    tests++;
    if (lat !== 17 || bc !== 17 || {result_hi, result_lo} !== 64'd42) begin
      fails++; $display("FAIL post_reset_op got lat=%0d busy=%0d r=%h_%h want 17 17 0_2a",
                        lat, bc, result_hi, result_lo);
    end
  endtask

  task automatic test_flush_in_idle();
    logic saw_done;
    @(negedge clk);
    drive_ops(32'd2, 32'd2, 32'h0, 32'h0, 1'b0, 1'b0);
    start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL idle_flush_busy got %0b want 0", busy); end
    saw_done = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (done) saw_done = 1'b1; end
    tests++;
    if (saw_done !== 1'b0 || {result_hi, result_lo} !== 64'd42) begin
      fails++; $display("FAIL idle_flush_no_op got done=%0b r=%h_%h want 0 0_2a",
                        saw_done, result_hi, result_lo);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_accumulate();
    test_start_ignored();
    test_abort();
    test_flush_in_idle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
